// File: rtl/key_flag_pkg.sv
// key_flag_pkg: shared types and constants for the key flag bank.
//   flag_mode_t - per-channel behaviour (STICKY / ONESHOT / TOGGLE)
//   MAX_FLAGS   - largest supported channel count
//   idxW()      - width of an index into n channels (minimum 1 bit)
package key_flag_pkg;

    typedef enum logic [1:0] {
        STICKY  = 2'd0,
        ONESHOT = 2'd1,
        TOGGLE  = 2'd2
    } flag_mode_t;

    localparam int MAX_FLAGS = 16;

    function automatic int idxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_flag_timer.sv
// key_flag_timer: auto-clear counter for one ONESHOT channel.
//   clk, rst_n - clock, synchronous active-low reset
//   restart    - effective set this cycle; counter goes back to 0
//   keep       - channel flag will be 1 after this edge; when low the count is dropped
//   flag       - current channel flag
//   expire     - flag is 1 and the counter sits at terminal count
module key_flag_timer
    import key_flag_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic keep,
    input  logic flag,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Saturates at TERM; only a restart or the flag dropping brings it back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n || !keep || restart)
            cnt <= '0;
        else if (cnt != TERM)
            cnt <= cnt + CW'(1);
    end

    assign expire = flag && (cnt == TERM);

endmodule

// File: rtl/key_flag_bank.sv
// key_flag_bank: bank of N_FLAGS set/clear flags with per-channel mode,
// mutual exclusivity group and optional one-shot auto-clear.
//   clk, rst_n    - clock, synchronous active-low reset
//   load          - synchronous clear of all flags/timers (last_idx kept)
//   set, clr      - per-channel set/toggle and clear requests
//   consume       - clears every ONESHOT flag
//   flags         - registered flag state
//   any_flag      - registered OR of flags
//   last_idx      - lowest channel with an effective set in the latest update
//   timeout_pulse - one-cycle strobe when a ONESHOT flag auto-clears
// Build option: define KEY_FLAG_TIMEOUT_EN to build the auto-clear timers;
// otherwise timeout_pulse is tied to 0 and ONESHOT flags never time out.
module key_flag_bank
    import key_flag_pkg::*;
#(
    parameter int                   N_FLAGS     = 4,
    parameter logic [N_FLAGS-1:0]   EXCL_MASK   = 4'b0011,
    parameter logic [N_FLAGS-1:0]   SET_PRIO    = 4'b0001,
    parameter logic [2*N_FLAGS-1:0] FLAG_MODE   = '0,
    parameter int                   TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [N_FLAGS-1:0]         set,
    input  logic [N_FLAGS-1:0]         clr,
    input  logic                       consume,
    output logic [N_FLAGS-1:0]         flags,
    output logic                       any_flag,
    output logic [idxW(N_FLAGS)-1:0]   last_idx,
    output logic [N_FLAGS-1:0]         timeout_pulse
);

    localparam int IW = idxW(N_FLAGS);

    logic [N_FLAGS-1:0] setWin, clrWin, cand, exclRise, winOh, exclKill;
    logic [N_FLAGS-1:0] nxt, upd, expire;
    logic [IW-1:0]      lastNext;

    always_comb begin
        // SET_PRIO bit decides which request wins when both are high.
        setWin = set & (~clr | SET_PRIO);
        clrWin = clr & ~setWin;
        cand   = flags;
        upd    = '0;
        for (int i = 0; i < N_FLAGS; i++) begin
            if (setWin[i])
                cand[i] = (FLAG_MODE[2*i +: 2] == TOGGLE) ? ~flags[i] : 1'b1;
            else if (clrWin[i])
                cand[i] = 1'b0;
            else if (FLAG_MODE[2*i +: 2] == ONESHOT && (consume || expire[i]))
                cand[i] = 1'b0;
        end

        // Only a genuine 0->1 rise claims the exclusive group; lowest index wins.
        exclRise = EXCL_MASK & setWin & ~flags & cand;
        winOh    = exclRise & (~exclRise + N_FLAGS'(1));
        exclKill = (|exclRise) ? (EXCL_MASK & ~winOh) : '0;
        nxt      = cand & ~exclKill;

        // Re-setting an already-high flag counts, except where it would toggle it off.
        for (int i = 0; i < N_FLAGS; i++)
            upd[i] = setWin[i] & nxt[i] & (~flags[i] | (FLAG_MODE[2*i +: 2] != TOGGLE));

        lastNext = last_idx;
        for (int i = N_FLAGS - 1; i >= 0; i--)
            if (upd[i]) lastNext = IW'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags    <= '0;
            any_flag <= 1'b0;
            last_idx <= '0;
        end else if (load) begin
            flags    <= '0;
            any_flag <= 1'b0;
        end else begin
            flags    <= nxt;
            any_flag <= |nxt;
            last_idx <= lastNext;
        end
    end

`ifdef KEY_FLAG_TIMEOUT_EN
    genvar g;
    generate
        for (g = 0; g < N_FLAGS; g++) begin : gChan
            if (FLAG_MODE[2*g +: 2] == ONESHOT) begin : gTimer
                key_flag_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) uTimer (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .restart (setWin[g] & nxt[g]),
                    .keep    (nxt[g] & ~load),
                    .flag    (flags[g]),
                    .expire  (expire[g])
                );
            end else begin : gNoTimer
                assign expire[g] = 1'b0;
            end
        end
    endgenerate

    // Pulse only when the timeout itself is what drops the flag.
    always_ff @(posedge clk) begin
        if (!rst_n || load)
            timeout_pulse <= '0;
        else
            timeout_pulse <= expire & ~setWin & ~clrWin & ~exclKill;
    end
`else
    assign expire        = '0;
    assign timeout_pulse = '0;
`endif

endmodule

// File: doc/key_flag_bank.md
KEY_FLAG_BANK -- requirements
Module: key_flag_bank

Interface
REQ-001 The block SHALL have parameter N_FLAGS, default 4, giving the number of flag channels (range 1..16).
REQ-002 The block SHALL have parameter EXCL_MASK [N_FLAGS-1:0], default 4'b0011, marking the mutually exclusive flags.
REQ-003 The block SHALL have parameter SET_PRIO [N_FLAGS-1:0], default 4'b0001, where bit=1 means set beats clr on that channel.
REQ-004 The block SHALL have parameter FLAG_MODE [2*N_FLAGS-1:0], default all STICKY, giving a per-channel mode from the package enum.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 1024, giving the one-shot auto-clear interval in clk cycles (range 2..65535).
REQ-006 The block SHALL have these ports:
 clk  in  1  rising-edge clock
 rst_n  in  1  synchronous active-low reset
 load  in  1  synchronous clear of all flags
 set  in  N_FLAGS  per-channel set/toggle request
 clr  in  N_FLAGS  per-channel clear request
 consume  in  1  clears all ONESHOT flags
 flags  out  N_FLAGS  registered flag state
 any_flag  out  1  OR of flags, registered
 last_idx  out  $clog2(N_FLAGS) or 1  index of most recent effective set
 timeout_pulse  out  N_FLAGS  one-cycle auto-clear strobe

Function
REQ-007 All outputs SHALL be registered and SHALL update on the rising clk edge after the inputs are sampled, giving a latency of 1 cycle.
REQ-008 The per-cycle priority SHALL be: rst_n low > load > exclusivity clear > set/clr (ordered per SET_PRIO) > consume/timeout > hold.
REQ-009 A STICKY channel SHALL go to 1 on an effective set and to 0 on an effective clr.
REQ-010 A ONESHOT channel SHALL behave as STICKY and SHALL additionally clear on consume or on timeout.
REQ-011 A TOGGLE channel SHALL invert on each set-high cycle and SHALL go to 0 on clr.
REQ-012 For set and clr high together on a TOGGLE channel, SET_PRIO SHALL decide between toggle and clear.
REQ-013 On an effective set of any channel i in EXCL_MASK, every other EXCL_MASK channel SHALL go to 0 in the same cycle, overriding its own set.
REQ-014 When several EXCL_MASK channels have effective sets in one cycle, the lowest index SHALL win and the others SHALL go to 0.
REQ-015 Exclusivity SHALL be triggered only by a 0->1 result; a toggle to 0 SHALL not disturb other channels.
REQ-016 last_idx SHALL take the lowest-indexed channel whose flag rises this cycle and SHALL otherwise hold.
REQ-017 A set on a flag that is already 1 SHALL not update last_idx, except on a non-TOGGLE channel, where it SHALL.
REQ-018 Each ONESHOT channel SHALL have a counter that restarts at 0 on every effective set and counts while the flag is 1.
REQ-019 When a ONESHOT counter reaches TIMEOUT_CYC-1, the flag SHALL clear on the next edge and timeout_pulse[i]=1 for that one cycle.
REQ-020 A set arriving in the expiry cycle SHALL win: the flag stays 1, the counter restarts and no pulse is issued.
REQ-021 A ONESHOT counter SHALL stop at terminal count, so counter width = $clog2(TIMEOUT_CYC) with no wrap.
REQ-022 A load or clr in the expiry cycle SHALL clear the flag and SHALL suppress the pulse.

Reset
REQ-023 When rst_n is sampled low, the block SHALL set flags=0, any_flag=0, last_idx=0, timeout_pulse=0 and all counters=0.
REQ-024 rst_n low mid-timeout SHALL abort the count with no pulse.
REQ-025 load SHALL have the same effect as rst_n on flags, counters and pulses but SHALL keep last_idx.

Configuration
REQ-026 Macro KEY_FLAG_TIMEOUT_EN SHALL control the timeout feature.
REQ-027 With KEY_FLAG_TIMEOUT_EN defined, the block SHALL include the counters and timeout_pulse behaviour of REQ-018..REQ-022.
REQ-028 With KEY_FLAG_TIMEOUT_EN undefined, no counters SHALL be built, timeout_pulse SHALL be tied to 0, and ONESHOT channels SHALL clear only on consume, clr or load.

Structure
REQ-029 Package key_flag_pkg SHALL hold the 2-bit enum flag_mode_t {STICKY=0, ONESHOT=1, TOGGLE=2} and the constant MAX_FLAGS=16.
REQ-030 Sub-module key_flag_timer SHALL be one counter plus expiry compare, instanced per ONESHOT channel under generate and only when the macro is defined.
REQ-031 The channel next-state logic, exclusivity resolution and last_idx encoder SHALL live in key_flag_bank.

Verification
REQ-032 Defaults: set=4'b0001, then next cycle set=4'b0010 -> flags 0001 then 0010, last_idx 0 then 1.
REQ-033 Defaults: set[0]=1 and clr[0]=1 together -> flags[0]=1; set[1]=1 and clr[1]=1 together -> flags[1]=0 (both checks cover SET_PRIO).
REQ-034 TIMEOUT_CYC=8, ch2 ONESHOT: set[2] pulse, then idle -> flags[2] clears and timeout_pulse[2]=1 exactly 8 cycles after the set edge.
REQ-035 Same config, re-set in the expiry cycle -> no pulse, and expiry occurs 8 cycles later; with the macro undefined -> flag held until consume.
REQ-036 Ch3 TOGGLE: set[3] high for 3 cycles -> flags[3] shows 1,0,1.
REQ-037 rst_n=0 for 1 cycle at counter=5 -> all outputs 0 and no timeout_pulse.
